// File: rtl/seq_checker_pkg.sv
// Shared types and default parameter values for the sequence checker.
package seq_checker_pkg;

  typedef enum logic {
    StHunt = 1'b0,
    StLock = 1'b1
  } state_e;

  localparam int unsigned DefN       = 10;
  localparam int unsigned DefLockCnt = 4;
  localparam int unsigned DefErrW    = 16;
  // Run counter only needs to reach LOCK_CNT, whose legal maximum is 255.
  localparam int unsigned RunW       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] OneW = W'(1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + OneW;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_checker.sv
// Checks that a sampled data stream increments by one; locks after LOCK_CNT good steps.
// Optional err_sticky output enabled by defining SEQ_CHECKER_STICKY_EN.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int unsigned N        = DefN,
  parameter int unsigned LOCK_CNT = DefLockCnt,
  parameter int unsigned ERR_W    = DefErrW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [N-1:0]     idata,
  output logic             locked,
  output logic             err_pulse,
`ifdef SEQ_CHECKER_STICKY_EN
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky
`else
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam logic [N-1:0]    OneN     = N'(1);
  localparam logic [RunW-1:0] OneR     = RunW'(1);
  localparam logic [RunW-1:0] LockCntR = RunW'(LOCK_CNT);

  state_e          state_q, state_d;
  logic [N-1:0]    prev_q, prev_d;
  logic            prev_vld_q, prev_vld_d;
  logic [RunW-1:0] run_q, run_d;
  logic            err_pulse_q, err_pulse_d;
  logic            correct;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;
    // Modular add handles the 2^N-1 -> 0 wrap.
    correct     = prev_vld_q && (idata == prev_q + OneN);

    if (ce) begin
      prev_d     = idata;
      prev_vld_d = 1'b1;
      if (prev_vld_q) begin
        unique case (state_q)
          StHunt: begin
            if (!correct) begin
              run_d = '0;
            end else if (run_q + OneR == LockCntR) begin
              state_d = StLock;
              run_d   = '0;
            end else begin
              run_d = run_q + OneR;
            end
          end
          StLock: begin
            if (!correct) begin
              err_pulse_d = 1'b1;
              state_d     = StHunt;
              run_d       = '0;
            end
          end
          default: state_d = StHunt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      run_q       <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      run_q       <= run_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == StLock);
  assign err_pulse = err_pulse_q;

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_pulse_d),
    .cnt  (err_cnt)
  );

`ifdef SEQ_CHECKER_STICKY_EN
  logic err_sticky_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else if (err_pulse_d) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios then random stream vs. a reference model.
module tb_seq_checker;

  localparam int unsigned N        = 10;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned ERR_W    = 16;
  localparam int          Mod      = 1 << N;
  localparam int          ErrMax   = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ce = 1'b0;
  logic [N-1:0]     idata = '0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
`ifdef SEQ_CHECKER_STICKY_EN
  logic             err_sticky;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed directly in terms of the stream rules.
  int m_prev     = 0;
  bit m_have     = 0;
  int m_run      = 0;
  bit m_locked   = 0;
  int m_err      = 0;
  bit m_pulse    = 0;
  bit m_sticky   = 0;
  bit last_pulse = 0;

  seq_checker #(
    .N       (N),
    .LOCK_CNT(LOCK_CNT),
    .ERR_W   (ERR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .idata    (idata),
    .locked   (locked),
    .err_pulse(err_pulse),
`ifdef SEQ_CHECKER_STICKY_EN
    .err_cnt  (err_cnt),
    .err_sticky(err_sticky)
`else
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit c, input int d);
    m_pulse = 0;
    if (!r) begin
      m_prev = 0; m_have = 0; m_run = 0; m_locked = 0; m_err = 0; m_sticky = 0;
    end else if (c) begin
      if (m_have) begin
        bit good;
        good = (d == (m_prev + 1) % Mod);
        if (m_locked) begin
          if (!good) begin
            m_pulse  = 1;
            m_sticky = 1;
            m_locked = 0;
            m_run    = 0;
            if (m_err < ErrMax) m_err++;
          end
        end else if (good) begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_locked = 1;
            m_run    = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      m_prev = d;
      m_have = 1;
    end
  endtask

  task automatic step(input bit r, input bit c, input int d);
    rst_n = r;
    ce    = c;
    idata = N'(d);
    @(posedge clk);
    #1;
    model_update(r, c, d);
    check("locked", 32'(locked), 32'(m_locked));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("no_double_pulse", 32'(err_pulse & last_pulse), 32'd0);
`ifdef SEQ_CHECKER_STICKY_EN
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
`endif
    last_pulse = err_pulse;
  endtask

  initial begin
    int nxt;
    bit r, c;
    int d;

    step(0, 0, 0);
    step(0, 1, 77);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);

    // Lock on 0..4.
    for (int i = 0; i <= 3; i++) step(1, 1, i);
    check("not_locked_at_3", 32'(locked), 32'd0);
    step(1, 1, 4);
    check("locked_at_4", 32'(locked), 32'd1);

    // Wrap while locked.
    step(0, 0, 0);
    for (int i = 1016; i <= 1023; i++) step(1, 1, i);
    step(1, 1, 0);
    step(1, 1, 1);
    check("wrap_locked", 32'(locked), 32'd1);
    check("wrap_no_err", 32'(err_cnt), 32'd0);

    // Break with 13, then relock on 14..17.
    for (int i = 2; i <= 11; i++) step(1, 1, i);
    step(1, 1, 13);
    check("break_pulse", 32'(err_pulse), 32'd1);
    check("break_cnt", 32'(err_cnt), 32'd1);
    check("break_unlock", 32'(locked), 32'd0);
    for (int i = 14; i <= 17; i++) step(1, 1, i);
    check("relock_17", 32'(locked), 32'd1);

    // ce gating: 99s ignored, run advances through 6..9.
    step(1, 1, 5);
    step(1, 0, 99);
    check("gated_no_pulse", 32'(err_pulse), 32'd0);
    step(1, 1, 6);
    step(1, 0, 99);
    for (int i = 7; i <= 9; i++) step(1, 1, i);
    check("relock_gated", 32'(locked), 32'd1);

    // Third break, relock, then reset while locked.
    step(1, 1, 20);
    for (int i = 21; i <= 24; i++) step(1, 1, i);
    check("err_cnt_3", 32'(err_cnt), 32'd3);
    step(0, 1, 25);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    for (int i = 500; i <= 504; i++) step(1, 1, i);
    check("relock_504", 32'(locked), 32'd1);

    // Random stream: mostly incrementing, occasional jumps, gaps and resets.
    nxt = 505;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 249) != 0);
      c = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, Mod - 1)) : nxt;
      step(r, c, d);
      if (c) nxt = (d + 1) % Mod;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter N, default 10: width of the checked data word.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive correct increments required to reach LOCK; legal range 1..255.
REQ-003 Parameter ERR_W, default 16: width of the error counter.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port ce, input, 1: sample qualifier; idata is consumed only on clk edges with ce=1.
REQ-007 Port idata, input, N: data stream from the upstream delay line (expected to be a free-running +1 counter).
REQ-008 Port locked, output, 1: high while the state machine is in LOCK.
REQ-009 Port err_pulse, output, 1: one-cycle pulse per sequence break detected in LOCK.
REQ-010 Port err_cnt, output, ERR_W: saturating count of sequence breaks detected in LOCK.

Function
REQ-011 The block SHALL keep a registered copy prev of the last accepted sample, plus a valid flag prev_vld.
REQ-012 A sample is correct iff prev_vld=1 and idata == (prev + 1) mod 2^N; wrap from 2^N-1 to 0 SHALL count as correct.
REQ-013 The FSM SHALL have exactly two states: HUNT (reset state) and LOCK.
REQ-014 The first accepted sample after reset SHALL only load prev and set prev_vld, with no compare.
REQ-015 In HUNT, on each accepted sample: correct -> run counter +1; incorrect -> run counter cleared to 0; no error reported.
REQ-016 HUNT->LOCK SHALL occur on the edge where the run counter reaches LOCK_CNT; locked SHALL rise on that same edge (registered output).
REQ-017 In LOCK, an incorrect sample SHALL cause: err_pulse=1 for exactly the next cycle, err_cnt+1 (held at 2^ERR_W-1 once saturated), transition to HUNT, run counter cleared.
REQ-018 Every accepted sample, correct or not, SHALL be loaded into prev.
REQ-019 With ce=0, state, prev, run counter and err_cnt SHALL hold, and err_pulse SHALL be 0.
REQ-020 err_pulse SHALL never be high for two consecutive cycles.
REQ-021 Latency: locked and err_pulse SHALL change on the clk edge that accepts the deciding sample (one register stage, no combinational path from idata to outputs).

Reset
REQ-022 When rst_n=0 at a rising clk edge: state=HUNT, prev=0, prev_vld=0, run=0, locked=0, err_pulse=0, err_cnt=0.
REQ-023 Reset asserted mid-stream SHALL take priority over ce and any pending compare; the first sample after release is treated per REQ-014.

Configuration
REQ-024 Macro SEQ_CHECKER_STICKY_EN: when defined, the block SHALL add output err_sticky (1 bit), set on the edge of the first err_pulse and cleared only by reset.
REQ-025 Without SEQ_CHECKER_STICKY_EN, port err_sticky and its register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026 Package seq_checker_pkg SHALL hold the FSM state encoding (HUNT, LOCK) and the default values of N, LOCK_CNT and ERR_W.
REQ-027 The saturating error counter SHALL be a separate sub-module, sat_counter (parameter W, inputs clk, rst_n, inc; output cnt).

Verification (N=10, LOCK_CNT=4, ERR_W=16)
REQ-028 Reset release, ce=1, idata 0,1,2,3,4 -> locked=1 on the edge accepting sample 4; err_cnt=0.
REQ-029 Locked stream 1020,1021,1022,1023,0,1 -> wrap accepted, locked stays 1, err_pulse never asserted.
REQ-030 Locked stream 10,11,13 -> err_pulse high for exactly one cycle after 13 is accepted, err_cnt=1, locked=0; then 14,15,16,17 -> relock after 17.
REQ-031 ce toggling 1,0,1,0 while idata 5,99,6,99 -> samples 99 ignored, no error, run counter advances.
REQ-032 rst_n=0 for one cycle while locked with err_cnt=3 -> all outputs 0 next cycle; following stream 500,501..504 relocks with no error.
REQ-033 With SEQ_CHECKER_STICKY_EN, induce two breaks -> err_sticky=1 after the first and remains 1, err_cnt=2; cleared only by rst_n=0.
